// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder reusing one 4-bit ripple chain, LSB nibble first
// Optional feature: define NIBBLE_SERIAL_OVF_EN to add the registered signed-overflow output ovf.

// One 4-bit ripple-carry chain; the only adder hardware in the block.
module nibble_adder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef NIBBLE_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operand shift registers: the low nibble is always the one being added.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Carry between nibbles lives only here; it never ripples combinationally across nibbles.
  logic             carry;
  logic [IDXW-1:0]  idx;
  // Partial sum fills from the top, so after NIB shifts nibble 0 sits at the bottom.
  logic [WIDTH-1:0] psum;

  logic [3:0]       nib_s;
  logic             nib_co;
  logic [WIDTH-1:0] nib_ext;
  logic [WIDTH-1:0] psum_next;
  logic             accept;
  logic             last_nib;

  nibble_adder4 u_chain (
    .x  (a_sh[3:0]),
    .y  (b_sh[3:0]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  assign nib_ext   = WIDTH'(nib_s);
  assign psum_next = (psum >> 4) | (nib_ext << (WIDTH - 4));
  assign accept    = (state == S_IDLE) && in_valid;
  assign last_nib  = (idx == IDXW'(NIB - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, NIB add cycles, hold in DONE until the consumer takes it.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid)  state_next = S_ADD;
      S_ADD:  if (last_nib)  state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: in_ready  = 1'b1;
      S_ADD:  busy      = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  // Datapath: capture on accept, shift one nibble per ADD cycle, publish result on the last nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      psum  <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      idx   <= '0;
      psum  <= '0;
    end else if (state == S_ADD) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      carry <= nib_co;
      psum  <= psum_next;
      idx   <= idx + IDXW'(1);
      if (last_nib) begin
        sum   <= psum_next;
        c_out <= nib_co;
      end
    end
  end

`ifdef NIBBLE_SERIAL_OVF_EN
  logic a_msb;
  logic b_msb;

  // Signed overflow: operand signs agree but the result sign differs; held alongside sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == S_ADD) && last_nib) begin
      ovf <= (a_msb == b_msb) && (psum_next[WIDTH-1] != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Present operands at a negedge; the following posedge accepts them (caller ensures IDLE).
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    @(negedge clk);
    a        = av;
    b        = bv;
    c_in     = cv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid; 20 means it never came.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b exp 0", c_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    issue(16'h1234, 16'h4321, 1'b0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b in_ready=%b exp 1/0", busy, in_ready); end
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
    checks++; if (sum !== 16'h5555 || c_out !== 1'b0) begin errors++; $display("FAIL basic_sum got %h/%b exp 5555/0", sum, c_out); end
`ifdef NIBBLE_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", ovf); end
`endif
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_carry_ripple();
    int lat;
    issue(16'hFFFF, 16'h0000, 1'b1);
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency got %0d exp 4", lat); end
    checks++; if (sum !== 16'h0000 || c_out !== 1'b1) begin errors++; $display("FAIL ripple_sum got %h/%b exp 0000/1", sum, c_out); end
    handshake();
  endtask

  task automatic test_signed_edges();
    int lat;
    issue(16'h8000, 16'h8000, 1'b0);
    wait_valid(lat);
    checks++; if (sum !== 16'h0000 || c_out !== 1'b1) begin errors++; $display("FAIL neg_ovf_sum got %h/%b exp 0000/1", sum, c_out); end
`ifdef NIBBLE_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL neg_ovf_flag got %b exp 1", ovf); end
`endif
    handshake();
    issue(16'h7FFF, 16'h0001, 1'b0);
    wait_valid(lat);
    checks++; if (sum !== 16'h8000 || c_out !== 1'b0) begin errors++; $display("FAIL pos_ovf_sum got %h/%b exp 8000/0", sum, c_out); end
`ifdef NIBBLE_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pos_ovf_flag got %b exp 1", ovf); end
`endif
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h0F0F, 16'h0101, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 4 || sum !== 16'h1010) begin errors++; $display("FAIL bp_result got lat=%0d sum=%h exp 4/1010", lat, sum); end
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h1010 || c_out !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got out_valid=%b sum=%h c_out=%b in_ready=%b exp 1/1010/0/0", i, out_valid, sum, c_out, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_capture got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat;
    issue(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_ctrl got in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
    checks++; if (sum !== 16'h0000 || c_out !== 1'b0) begin errors++; $display("FAIL abort_sum got %h/%b exp 0000/0", sum, c_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result cycle %0d got %b exp 0", i, out_valid); end
    end
    issue(16'h00FF, 16'h0001, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 4 || sum !== 16'h0100 || c_out !== 1'b0) begin errors++; $display("FAIL abort_recover got lat=%0d sum=%h c_out=%b exp 4/0100/0", lat, sum, c_out); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    a = 16'h0001; b = 16'h0002; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 16'hABCD; b = 16'h1111;
    wait_valid(lat);
    checks++; if (lat !== 4 || sum !== 16'h0003 || c_out !== 1'b0) begin errors++; $display("FAIL b2b_first got lat=%0d sum=%h c_out=%b exp 4/0003/0", lat, sum, c_out); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_handshake got out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got busy=%b in_ready=%b exp 1/0", busy, in_ready); end
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat !== 4 || sum !== 16'hBCDE || c_out !== 1'b0) begin errors++; $display("FAIL b2b_second got lat=%0d sum=%h c_out=%b exp 4/bcde/0", lat, sum, c_out); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_signed_edges();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
